// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver_if
// Description : Bundles the data/strobe inputs and the SEG/DP/AN pin outputs
//               of the seven-segment scan driver. The master side produces
//               hex nibbles and strobes; the slave side is the driver itself.
// Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] value;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   dig_en;
  logic                  lz_suppress;
  logic                  load;
  logic [6:0]            SEG;
  logic                  DP;
  logic [N_DIGITS-1:0]   AN;

  modport master (
    output value, dp_in, dig_en, lz_suppress, load,
    input  SEG, DP, AN
  );

  modport slave (
    input  value, dp_in, dig_en, lz_suppress, load,
    output SEG, DP, AN
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed common-anode seven-segment driver. Captures
//               a packed hex word into shadow registers on a load strobe and
//               lights one digit per refresh slot, with per-digit enable,
//               decimal points, leading-zero suppression and a blank window
//               at the start of every slot to avoid ghosting.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] c_blank    = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_DIGITS - 1);

  // Reject unusable configurations while elaborating
  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
    $error("seg7_scan_driver: N_DIGITS must be within 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seg7_scan_driver: REFRESH_DIV must be at least 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be below REFRESH_DIV");
  end

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [4*N_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [N_DIGITS-1:0]   sh_dp_q,  sh_dp_d;
  logic [N_DIGITS-1:0]   sh_en_q,  sh_en_d;
  logic [N_DIGITS-1:0]   an_q,     an_d;
  logic [6:0]            seg_q,    seg_d;
  logic                  dp_q,     dp_d;

  logic [N_DIGITS-1:0]   w_zero_from;
  logic [N_DIGITS-1:0]   w_visible;
  logic [3:0]            w_nib;
  logic [N_DIGITS-1:0]   w_onehot;

  // Slot prescaler, digit index and shadow capture
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    if (cnt_q == c_cnt_last) begin
      cnt_d = '0;
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
    end
    if (bus.load) begin
      sh_val_d = bus.value;
      sh_dp_d  = bus.dp_in;
      sh_en_d  = bus.dig_en;
    end
  end

  // Visibility: digit i is dark under suppression when every enabled digit
  // at or above it is zero; disabled digits do not stop the suppression run
  always_comb begin : visibility
    logic tail;
    tail        = 1'b1;
    w_zero_from = '0;
    w_visible   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      tail           = tail & (~sh_en_q[i] | (sh_val_q[4*i +: 4] == 4'h0));
      w_zero_from[i] = tail;
      w_visible[i]   = sh_en_q[i] &
                       ~(bus.lz_suppress & w_zero_from[i] & (i != 0));
    end
  end

  // Next pin values from the current slot position and shadow state
  always_comb begin
    w_nib    = sh_val_q[4*int'(idx_q) +: 4];
    w_onehot = N_DIGITS'(1) << idx_q;
    an_d     = '1;
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    if (!(cnt_q < c_blank) && w_visible[idx_q]) begin
      an_d  = ~w_onehot;
      seg_d = seg_decode(w_nib);
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  // State and registered outputs; reset blanks the display and clears shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      an_q     <= '1;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      sh_en_q  <= sh_en_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver. A reference model
//               derives each cycle's pins from elapsed time since reset and
//               the captured shadow word; a monitor compares on the falling
//               edge and also watches anode overlap and blank gaps.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  typedef logic [N+7:0] exp_t;   // {AN, SEG, DP}

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Segment table straight from the character list
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference state: cycles elapsed since reset plus captured shadow copy
  int             m_t;
  logic [4*N-1:0] m_val;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_en;
  exp_t           exp_q[$];

  function automatic exp_t blank_out();
    logic [N-1:0] an;
    an = '1;
    return {an, 7'b1111111, 1'b1};
  endfunction

  function automatic exp_t model_out(input logic lz);
    int           pos;
    int           idx;
    bit           vis;
    bit           any_nz;
    logic [N-1:0] an;
    logic [3:0]   nib;
    pos = m_t % RD;
    idx = (m_t / RD) % N;
    vis = m_en[idx];
    if (lz && idx != 0) begin
      any_nz = 0;
      for (int j = idx; j < N; j++)
        if (m_en[j] && m_val[4*j +: 4] != 4'h0) any_nz = 1;
      if (!any_nz) vis = 0;
    end
    if (pos < BC || !vis) return blank_out();
    an      = '1;
    an[idx] = 1'b0;
    nib     = m_val[4*idx +: 4];
    return {an, seg_tab[nib], ~m_dp[idx]};
  endfunction

  // Reference model: predicts what the pins show after this edge
  always @(posedge clk) begin
    if (rst) begin
      exp_q.push_back(blank_out());
      m_t   = 0;
      m_val = '0;
      m_dp  = '0;
      m_en  = '0;
    end else begin
      exp_q.push_back(model_out(bus.lz_suppress));
      m_t++;
      if (bus.load) begin
        m_val = bus.value;
        m_dp  = bus.dp_in;
        m_en  = bus.dig_en;
      end
    end
  end

  // Monitor: scoreboard compare, anode overlap and blank-gap checks
  int last_lit = -1;
  int gap      = 0;
  always @(negedge clk) begin
    exp_t e;
    int   cur;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.AN, bus.SEG, bus.DP} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t AN/SEG/DP got %b/%b/%b expected %b/%b/%b",
                 $time, bus.AN, bus.SEG, bus.DP, e[N+7:8], e[7:1], e[0]);
      end
      checks++;
      if ($countones(~bus.AN) > 1) begin
        failures++;
        $display("FAIL an_overlap t=%0t AN got %b expected at most one low bit",
                 $time, bus.AN);
      end
      if (rst || bus.AN == '1) begin
        gap++;
      end else begin
        cur = -1;
        for (int i = 0; i < N; i++) if (!bus.AN[i]) cur = i;
        if (last_lit >= 0 && cur != last_lit) begin
          checks++;
          if (gap < BC) begin
            failures++;
            $display("FAIL blank_gap t=%0t digit %0d->%0d gap got %0d expected >= %0d",
                     $time, last_lit, cur, gap, BC);
          end
        end
        last_lit = cur;
        gap      = 0;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d,
                         input logic [N-1:0] e, input logic lz);
    @(posedge clk);
    #1;
    bus.value       = v;
    bus.dp_in       = d;
    bus.dig_en      = e;
    bus.lz_suppress = lz;
    bus.load        = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  // Wait until the DUT is at slot position pos of digit idx (bounded)
  task automatic wait_slot(input int idx, input int pos);
    int k;
    k = 0;
    while (!(((m_t / RD) % N) == idx && (m_t % RD) == pos) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_slot timeout got no slot expected digit %0d pos %0d", idx, pos);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.value       = '0;
    bus.dp_in       = '0;
    bus.dig_en      = '0;
    bus.lz_suppress = 1'b0;
    bus.load        = 1'b0;
    run(3);
    rst = 1'b0;
    run(2);

    // Basic scan of 12AF with all digits enabled
    do_load(16'h12AF, 4'b0000, 4'b1111, 1'b0);
    run(2 * N * RD);

    // Leading-zero suppression
    do_load(16'h0050, 4'b0000, 4'b1111, 1'b1);
    run(N * RD + 3);
    do_load(16'h0000, 4'b0000, 4'b1111, 1'b1);
    run(N * RD + 3);

    // Enable mask with decimal point on digit 2
    do_load(16'h9C3E, 4'b0100, 4'b0101, 1'b0);
    run(N * RD + 3);

    // Inputs change without load: display must hold
    bus.value  = 16'h4567;
    bus.dig_en = 4'b1111;
    bus.dp_in  = 4'b1111;
    run(N * RD);

    // Load in the middle of digit 1's lit window
    wait_slot(1, 4);
    bus.load = 1'b1;
    run(1);
    bus.load = 1'b0;
    run(N * RD);

    // Reset during digit 2's lit window
    do_load(16'h8421, 4'b1010, 4'b1111, 1'b0);
    wait_slot(2, BC + 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(N * RD + 3);

    // Random traffic for ten scan periods
    for (int c = 0; c < 10 * N * RD; c++) begin
      bus.value = 16'($urandom);
      bus.dig_en = 4'($urandom);
      bus.dp_in = 4'($urandom);
      bus.load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus.lz_suppress = ~bus.lz_suppress;
      run(1);
    end
    bus.load = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display on the Nexys-class board. It captures a packed hex word into a shadow register on a load strobe and scans one digit per refresh slot. It supports per-digit enable, per-digit decimal points, leading-zero suppression and anti-ghosting blanking at every slot boundary. It sits between the switch/button logic (or any datapath producing hex nibbles) and the board's SEG/DP/AN pins.

## Interface
Parameters:
- N_DIGITS, 8, number of digits scanned; legal range 1..8
- REFRESH_DIV, 100000, clock cycles per digit slot; must be ≥ 2
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- value  in  4*N_DIGITS  packed hex nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit
- dig_en  in  N_DIGITS  digit enable mask, 1 = digit may be lit
- lz_suppress  in  1  1 = blank leading zero digits
- load  in  1  one-cycle strobe that copies value, dp_in and dig_en into the shadow registers
- SEG  out  7  segments, active-low, {g,f,e,d,c,b,a}
- DP  out  1  decimal point, active-low
- AN  out  N_DIGITS  anodes, active-low, at most one low at any time

## Operation
- Shadow registers: sh_val, sh_dp and sh_en load on the `load` edge. The display uses only the shadow copies, so inputs may change freely between strobes without tearing the display.
- Prescaler `cnt` counts 0..REFRESH_DIV-1.
- At cnt == REFRESH_DIV-1: cnt → 0 and `idx` advances.
- idx wrap rule: idx → 0 if idx == N_DIGITS-1, else idx+1.
- With N_DIGITS = 1, idx stays 0.
- Visibility: digit i is visible iff sh_en[i] = 1 and it is not suppressed.
- Leading-zero suppression applies when lz_suppress = 1. Digit i is suppressed iff all enabled digits j ≥ i hold nibble 0. Digit 0 is never suppressed.
- Decode, active-low:
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000
  - 4 → 0011001, 5 → 0010010, 6 → 0000010, 7 → 1111000
  - 8 → 0000000, 9 → 0010000, A → 0001000, b → 0000011
  - C → 1000110, d → 0100001, E → 0000110, F → 0001110
- Output rule: if cnt < BLANK_CYCLES or digit idx is not visible, then AN = all ones, SEG = 1111111 and DP = 1.
- Otherwise:
  - AN = ~(1 << idx)
  - SEG = decode(sh_val nibble idx)
  - DP = ~sh_dp[idx]
- Illegal parameter values are an elaboration-time $error.

## Timing
- All outputs are registered. Each output reflects the cnt, idx and shadow state of the previous cycle (1-cycle latency).
- Reset values:
  - AN = all ones, SEG = 1111111, DP = 1
  - cnt = 0, idx = 0
  - sh_val = 0, sh_dp = 0, sh_en = 0, so the display is dark until the first load
- rst has priority over load and over counting. Asserting rst mid-slot blanks the outputs on the next edge and restarts the scan at digit 0.
- load at edge k: new shadow contents appear on SEG/DP/AN at edge k+1 if the current slot is past its blank window.
- Full scan period = N_DIGITS × REFRESH_DIV cycles. Each slot lights its digit for REFRESH_DIV − BLANK_CYCLES cycles.
- Overlap: AN never has two bits low in the same cycle. Between two different lit digits there are at least BLANK_CYCLES cycles of all-ones AN.
- load coinciding with the idx wrap: the shadow update and the idx advance both take effect; there is no special case.

## Test plan
- Reset and load: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; hold rst 3 cycles → AN=1111, SEG=1111111, DP=1. Release rst, then load value=16'h12AF, dig_en=1111, dp_in=0 → scan shows:
  - digit 0: AN=1110, SEG=0001110
  - digit 1: AN=1101, SEG=0001000
  - digit 2: AN=1011, SEG=0100100
  - digit 3: AN=0111, SEG=1111001
  - each digit lit for 6 cycles after 2 blank cycles; idx wraps 3→0.
- Leading-zero suppression: same config, value=16'h0050, lz_suppress=1 → digits 3 and 2 are dark (AN=1111 in their slots), digits 1 and 0 show 5 and 0. With value=0 → only digit 0 shows 0.
- Enable mask and DP: dig_en=0101, dp_in=0100 → only slots 0 and 2 light; DP=0 only during digit 2's lit window.
- Tear-free update: change value without load → outputs unchanged for a full scan period. Pulse load mid-slot → SEG changes exactly 1 cycle later.
- Mid-scan reset: assert rst during digit 2's lit window → next edge AN=1111. After release the scan restarts at digit 0 with the shadow cleared.
- Non-overlap check: random value/dig_en/load traffic for 10 scan periods with assertions that at most one AN bit is low and that ≥ BLANK_CYCLES all-ones cycles occur between different lit digits.
